// File: rtl/alu_result_formatter.sv
// -----------------------------------------------------------------------------
// alu_result_formatter
//
// Purpose:
//   Takes one packed ALU result/status pair per handshake and turns it into
//   four BCD display digits plus sign and error flags. The conversion is a
//   shift-add-3 (double-dabble) pass. Every opcode has the same latency:
//   the outputs update CONV_CYCLES+2 edges after the accept edge.
//
// Optional feature (compile-time macro):
//   FMT_ZERO_BLANK_EN - when defined, leading zeros are shown as 4'hF (blank).
//                       When undefined, leading zeros are shown as 4'h0.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   request; only accepted while busy=0
//   op[1:0]        in   00 add (BCD), 01 sub, 10 mul, 11 div
//   result[7:0]    in   ALU result word
//   status         in   ALU carry/borrow/overflow/div-by-zero flag
//   busy           out  conversion in progress
//   done           out  one-cycle pulse when the outputs update
//   d3..d0[3:0]    out  BCD digits, d3 most significant; 4'hF = blank/error
//   neg            out  result negative (sub only)
//   err            out  result not displayable
// -----------------------------------------------------------------------------
module alu_result_formatter #(
  parameter int CONV_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] result,
  input  logic       status,
  output logic       busy,
  output logic       done,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       neg,
  output logic       err
);

  localparam logic [2:0] LP_LAST = 3'(CONV_CYCLES - 1);
  localparam logic [3:0] LP_BLANK = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_cnt;

  // Captured request
  logic [1:0]  r_op;
  logic [7:0]  r_result;
  logic        r_status;

  // Lane A converts the main magnitude (or the div quotient); lane B converts
  // the div remainder. Both run for the same number of iterations.
  logic [7:0]  r_bin_a;
  logic [11:0] r_bcd_a;
  logic [7:0]  r_bin_b;
  logic [7:0]  r_bcd_b;
  logic [11:0] w_adj_a;
  logic [7:0]  w_adj_b;
  logic [7:0]  w_mag;

  // Output registers
  logic [3:0]  r_d3, r_d2, r_d1, r_d0;
  logic        r_neg, r_err, r_done;

  // Decoded values presented to the output registers in DONE
  logic [3:0]  w_d3, w_d2, w_d1, w_d0;
  logic        w_neg, w_err;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_SHIFT;
      S_SHIFT: if (r_cnt == LP_LAST) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Double-dabble add-3 correction, one adjuster per BCD nibble
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj_a
      assign w_adj_a[gi*4 +: 4] = (r_bcd_a[gi*4 +: 4] >= 4'd5) ?
                                  r_bcd_a[gi*4 +: 4] + 4'd3 : r_bcd_a[gi*4 +: 4];
    end
    for (gi = 0; gi < 2; gi++) begin : g_adj_b
      assign w_adj_b[gi*4 +: 4] = (r_bcd_b[gi*4 +: 4] >= 4'd5) ?
                                  r_bcd_b[gi*4 +: 4] + 4'd3 : r_bcd_b[gi*4 +: 4];
    end
  endgenerate

  // Magnitude fed to lane A: negated for negative sub results, the quotient
  // nibble for div, the raw word otherwise (add does not use the converter).
  always_comb begin
    w_mag = r_result;
    if (r_op == 2'b01 && r_result[7]) begin
      w_mag = ~r_result + 8'd1;
    end else if (r_op == 2'b11) begin
      w_mag = {4'd0, r_result[3:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 3'd0;
      r_op     <= 2'd0;
      r_result <= 8'd0;
      r_status <= 1'b0;
      r_bin_a  <= 8'd0;
      r_bcd_a  <= 12'd0;
      r_bin_b  <= 8'd0;
      r_bcd_b  <= 8'd0;
      r_d3     <= 4'd0;
      r_d2     <= 4'd0;
      r_d1     <= 4'd0;
      r_d0     <= 4'd0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_result <= result;
            r_status <= status;
          end
        end
        S_LOAD: begin
          r_cnt   <= 3'd0;
          r_bin_a <= w_mag;
          r_bcd_a <= 12'd0;
          r_bin_b <= {4'd0, r_result[7:4]};
          r_bcd_b <= 8'd0;
        end
        S_SHIFT: begin
          r_cnt   <= r_cnt + 3'd1;
          r_bcd_a <= {w_adj_a[10:0], r_bin_a[7]};
          r_bin_a <= {r_bin_a[6:0], 1'b0};
          r_bcd_b <= {w_adj_b[6:0], r_bin_b[7]};
          r_bin_b <= {r_bin_b[6:0], 1'b0};
        end
        S_DONE: begin
          r_d3   <= w_d3;
          r_d2   <= w_d2;
          r_d1   <= w_d1;
          r_d0   <= w_d0;
          r_neg  <= w_neg;
          r_err  <= w_err;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-opcode decode of the converted digits
  // ---------------------------------------------------------------------------
  always_comb begin
    w_d3  = 4'd0;
    w_d2  = 4'd0;
    w_d1  = 4'd0;
    w_d0  = 4'd0;
    w_neg = 1'b0;
    w_err = 1'b0;
    case (r_op)
      2'b00: begin
        // Already BCD: carry is the tens digit
        w_d1  = {3'd0, r_status};
        w_d0  = r_result[3:0];
        w_err = (r_result[3:0] > 4'd9) || (r_result[7:4] != 4'd0);
      end
      2'b01: begin
        w_neg = r_result[7];
        w_d1  = r_bcd_a[7:4];
        w_d0  = r_bcd_a[3:0];
      end
      2'b10: begin
        w_d2 = r_bcd_a[11:8];
        w_d1 = r_bcd_a[7:4];
        w_d0 = r_bcd_a[3:0];
      end
      default: begin
        w_err = r_status;
        w_d3  = r_bcd_a[7:4];
        w_d2  = r_bcd_a[3:0];
        w_d1  = r_bcd_b[7:4];
        w_d0  = r_bcd_b[3:0];
      end
    endcase

`ifdef FMT_ZERO_BLANK_EN
    if (r_op == 2'b11) begin
      // Quotient and remainder are blanked independently on their tens digit
      if (w_d3 == 4'd0) w_d3 = LP_BLANK;
      if (w_d1 == 4'd0) w_d1 = LP_BLANK;
    end else if (w_d3 == 4'd0) begin
      w_d3 = LP_BLANK;
      if (w_d2 == 4'd0) begin
        w_d2 = LP_BLANK;
        if (w_d1 == 4'd0) w_d1 = LP_BLANK;
      end
    end
`endif

    if (w_err) begin
      w_d3  = LP_BLANK;
      w_d2  = LP_BLANK;
      w_d1  = LP_BLANK;
      w_d0  = LP_BLANK;
      w_neg = 1'b0;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign d3   = r_d3;
  assign d2   = r_d2;
  assign d1   = r_d1;
  assign d0   = r_d0;
  assign neg  = r_neg;
  assign err  = r_err;

endmodule
